div_seq: RTL and testbench
==========================

# div_seq

Parametrised sequential divider for the ALU: takes divisor then dividend over the shared input bus, runs a WIDTH-step non-restoring division, and returns quotient then remainder over the shared output bus. Adds a signed mode, divide-by-zero detection and a fixed, data-independent latency. An internal FSM drives the datapath in the same style as the other ALU sequential units.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2); iteration counter width is derived as $clog2(WIDTH+1)
- clk  in  1  rising-edge clock
- rst_b  in  1  reset, asynchronous, active-low
- enable  in  1  unit selected by ALU; start is ignored while low
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  sampled with start; 1 = two's-complement operands
- inbus  in  WIDTH  operand bus (divisor in LOAD_M, dividend in LOAD_Q)
- outbus  out  WIDTH  quotient in OUT_Q, remainder in OUT_R, 0 otherwise
- out_valid  out  1  high in OUT_Q and OUT_R
- done  out  1  high in OUT_R only
- busy  out  1  high in every state except IDLE
- div_by_zero  out  1  high in OUT_Q/OUT_R when divisor was 0

## Operation
- Registers: M (WIDTH+1), A (WIDTH+1, signed partial remainder), Q (WIDTH), count, mode, sign_q, sign_r.
- IDLE: start & enable at an edge → LOAD_M; mode latched.
- LOAD_M: M ← inbus. → LOAD_Q.
- LOAD_Q: Q ← inbus, A ← 0. → CHECK.
- CHECK: divisor 0 → R ← raw dividend, Q ← all ones, flag set, → OUT_Q. Otherwise in signed mode sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend); M, Q replaced by magnitudes (unsigned interpretation, so the magnitude of −2^(WIDTH−1) fits). count ← WIDTH. → ITER.
- ITER, one step per cycle: shift {A,Q} left 1; if the old A was ≥ 0 then A ← A − M, else A ← A + M; Q[0] ← ~A[WIDTH]; count −1; at count = 1 → CORR.
- CORR: if A < 0 then A ← A + M. → FIX.
- FIX: signed mode only: Q negated if sign_q; A negated if sign_r. → OUT_Q.
- OUT_Q: outbus = Q. → OUT_R. OUT_R: outbus = A[WIDTH−1:0]. → IDLE.
- Arithmetic is modulo 2^WIDTH on outputs. Signed −2^(WIDTH−1) / −1 → Q = 2^(WIDTH−1) pattern, R = 0, no flag.
- start while busy, or with enable low: ignored, no state change, no queueing.

## Timing
- Reset (any state, any time): state IDLE, all registers 0, outbus/out_valid/done/busy/div_by_zero = 0; an aborted operation produces no output.
- Start sampled at the end of cycle 0. Divisor must be on inbus in cycle 1, dividend in cycle 2.
- Normal: CHECK in cycle 3, ITER in cycles 4..WIDTH+3, CORR WIDTH+4, FIX WIDTH+5, OUT_Q WIDTH+6, OUT_R WIDTH+7, IDLE WIDTH+8. A new start is accepted in cycle WIDTH+8.
- Divide-by-zero: OUT_Q in cycle 4, OUT_R in cycle 5, IDLE in cycle 6.
- All outputs are decoded from registered state and registers only; no combinational path from inputs to outputs.

## Structure
- Shared package div_pkg: state enum (IDLE, LOAD_M, LOAD_Q, CHECK, ITER, CORR, FIX, OUT_Q, OUT_R) as a 4-bit typedef.
- Sub-module div_seq_ctrl: FSM and iteration counter. Inputs: start, enable, cnt_done, a_sign, m_zero. Outputs: state plus datapath load/shift/add-sub/correct/fix/output strobes. The datapath stays in div_seq.

## Test plan
WIDTH = 8.
- Unsigned 100 / 7 → OUT_Q 0x0E, OUT_R 0x02; out_valid in cycles 14–15, done in cycle 15, busy cycles 1–15.
- Signed −100 (0x9C) / 7 → Q 0xF2 (−14), R 0xFE (−2); signed 100 / −7 → Q 0xF2, R 0x02.
- 100 / 0 → Q 0xFF, R 0x64, div_by_zero = 1 in cycles 4–5, IDLE in cycle 6.
- Signed 0x80 / 0xFF → Q 0x80, R 0x00, div_by_zero = 0; unsigned 255 / 1 → Q 0xFF, R 0.
- start pulsed during ITER, and start with enable = 0 in IDLE → ignored, results unchanged.
- rst_b low in cycle 6 (mid-ITER) → all outputs 0 immediately; a fresh 50 / 5 then returns Q 0x0A, R 0x00 with nominal timing.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding.
package div_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_M = 4'd1,
    LOAD_Q = 4'd2,
    CHECK  = 4'd3,
    ITER   = 4'd4,
    CORR   = 4'd5,
    FIX    = 4'd6,
    OUT_Q  = 4'd7,
    OUT_R  = 4'd8
  } state_e;

endpackage

// File: rtl/div_seq_ctrl.sv
// Divider sequencer: state register, iteration counter and datapath strobes.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             enable,
  input  logic             cnt_done,
  input  logic             a_sign,
  input  logic             m_zero,
  output state_e           state,
  output logic [CNT_W-1:0] cnt,
  output logic             accept,
  output logic             ld_m,
  output logic             ld_q,
  output logic             chk,
  output logic             iter,
  output logic             corr_add,
  output logic             fix
);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:   if (start && enable) state_d = LOAD_M;
      LOAD_M: state_d = LOAD_Q;
      LOAD_Q: state_d = CHECK;
      CHECK: begin
        if (m_zero) begin
          state_d = OUT_Q;
        end else begin
          state_d = ITER;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_done) state_d = CORR;
      end
      CORR:   state_d = FIX;
      FIX:    state_d = OUT_Q;
      OUT_Q:  state_d = OUT_R;
      OUT_R:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state    = state_q;
  assign cnt      = cnt_q;
  assign accept   = (state_q == IDLE) && start && enable;
  assign ld_m     = (state_q == LOAD_M);
  assign ld_q     = (state_q == LOAD_Q);
  assign chk      = (state_q == CHECK);
  assign iter     = (state_q == ITER);
  assign corr_add = (state_q == CORR) && a_sign;
  assign fix      = (state_q == FIX);

endmodule

// File: rtl/div_seq.sv
// Sequential non-restoring divider with signed mode, divide-by-zero flag
// and fixed latency; operands and results share single buses.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             enable,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH+1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             accept, ld_m, ld_q, chk, iter, corr_add, fix;
  logic             cnt_done, m_zero;

  logic [WIDTH:0]   m_d, m_q, a_d, a_q, a_sh, a_nx;
  logic [WIDTH-1:0] q_d, q_q;
  logic             mode_d, mode_q, qneg_d, qneg_q, rneg_d, rneg_q, dbz_d, dbz_q;

  assign cnt_done = (cnt == CNT_W'(1));
  assign m_zero   = (m_q == '0);

  div_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .enable   (enable),
    .cnt_done (cnt_done),
    .a_sign   (a_q[WIDTH]),
    .m_zero   (m_zero),
    .state    (state),
    .cnt      (cnt),
    .accept   (accept),
    .ld_m     (ld_m),
    .ld_q     (ld_q),
    .chk      (chk),
    .iter     (iter),
    .corr_add (corr_add),
    .fix      (fix)
  );

  always_comb begin
    m_d    = m_q;
    a_d    = a_q;
    q_d    = q_q;
    mode_d = mode_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dbz_d  = dbz_q;
    a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_nx   = a_q[WIDTH] ? (a_sh + m_q) : (a_sh - m_q);

    if (accept) mode_d = signed_mode;
    if (ld_m) begin
      m_d   = {1'b0, inbus};
      dbz_d = 1'b0;
    end
    if (ld_q) begin
      q_d = inbus;
      a_d = '0;
    end
    if (chk) begin
      if (m_zero) begin
        a_d   = {1'b0, q_q};
        q_d   = '1;
        dbz_d = 1'b1;
      end else begin
        qneg_d = mode_q && (q_q[WIDTH-1] ^ m_q[WIDTH-1]);
        rneg_d = mode_q && q_q[WIDTH-1];
        // Magnitudes are read as unsigned, so -2^(WIDTH-1) maps onto itself.
        if (mode_q && q_q[WIDTH-1]) q_d = -q_q;
        if (mode_q && m_q[WIDTH-1]) m_d = {1'b0, -m_q[WIDTH-1:0]};
      end
    end
    if (iter) begin
      a_d = a_nx;
      q_d = {q_q[WIDTH-2:0], ~a_nx[WIDTH]};
    end
    if (corr_add) a_d = a_q + m_q;
    if (fix) begin
      if (mode_q && qneg_q) q_d = -q_q;
      if (mode_q && rneg_q) a_d = -a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      mode_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      m_q    <= m_d;
      a_q    <= a_d;
      q_q    <= q_d;
      mode_q <= mode_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dbz_q  <= dbz_d;
    end
  end

  always_comb begin
    outbus = '0;
    if (state == OUT_Q) outbus = q_q;
    if (state == OUT_R) outbus = a_q[WIDTH-1:0];
  end

  assign out_valid   = (state == OUT_Q) || (state == OUT_R);
  assign done        = (state == OUT_R);
  assign busy        = (state != IDLE);
  assign div_by_zero = out_valid && dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (WIDTH=8): results, cycle timing, ignored starts, reset abort.
module tb_div_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         enable = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] inbus = '0;
  logic [W-1:0] outbus;
  logic         out_valid, done, busy, div_by_zero;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .enable      (enable),
    .start       (start),
    .signed_mode (signed_mode),
    .inbus       (inbus),
    .outbus      (outbus),
    .out_valid   (out_valid),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 raises start; checks land on the cycle numbers the block promises.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] dvsr,
                        input logic [W-1:0] dvnd, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edbz, input bit poke);
    int qc;
    qc = edbz ? 4 : W + 6;
    step();
    start = 1'b1; enable = 1'b1; signed_mode = sgn; inbus = '0;
    step();
    start = 1'b0; inbus = dvsr;
    chk({tag, ".busy1"}, busy, 1);
    step();
    inbus = dvnd;
    step();
    inbus = '0;
    for (int c = 4; c <= qc + 2; c++) begin
      step();
      start = (poke && c == 6);
      if (c == qc - 1) chk({tag, ".vld_early"}, out_valid, 0);
      if (c == qc) begin
        chk({tag, ".q"}, outbus, eq);
        chk({tag, ".vld_q"}, out_valid, 1);
        chk({tag, ".done_q"}, done, 0);
        chk({tag, ".dbz_q"}, div_by_zero, edbz);
      end
      if (c == qc + 1) begin
        chk({tag, ".r"}, outbus, er);
        chk({tag, ".done_r"}, done, 1);
        chk({tag, ".dbz_r"}, div_by_zero, edbz);
        chk({tag, ".busy_r"}, busy, 1);
      end
      if (c == qc + 2) begin
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".vld_idle"}, out_valid, 0);
        chk({tag, ".bus_idle"}, outbus, 0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst.busy", busy, 0);
    chk("rst.vld", out_valid, 0);
    chk("rst.bus", outbus, 0);
    chk("rst.done", done, 0);
    chk("rst.dbz", div_by_zero, 0);
    #10 rst_b = 1'b1;

    run_op("u100_7",  1'b0, 8'd7,   8'd100, 8'h0E, 8'h02, 1'b0, 1'b0);
    run_op("s-100_7", 1'b1, 8'd7,   8'h9C,  8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op("s100_-7", 1'b1, 8'hF9,  8'd100, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_op("u100_0",  1'b0, 8'd0,   8'd100, 8'hFF, 8'h64, 1'b1, 1'b0);
    run_op("s80_ff",  1'b1, 8'hFF,  8'h80,  8'h80, 8'h00, 1'b0, 1'b0);
    run_op("u255_1",  1'b0, 8'd1,   8'd255, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("poke",    1'b0, 8'd7,   8'd100, 8'h0E, 8'h02, 1'b0, 1'b1);

    // start with enable low must not leave IDLE
    step();
    enable = 1'b0; start = 1'b1;
    step();
    start = 1'b0; enable = 1'b1;
    chk("en0.busy", busy, 0);
    step();
    chk("en0.busy2", busy, 0);
    run_op("after_en0", 1'b0, 8'd7, 8'd100, 8'h0E, 8'h02, 1'b0, 1'b0);

    // abort mid-iteration
    step();
    start = 1'b1; signed_mode = 1'b0;
    step();
    start = 1'b0; inbus = 8'd7;
    step();
    inbus = 8'd100;
    step();
    inbus = '0;
    repeat (3) step();
    chk("abort.busy_pre", busy, 1);
    rst_b = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.vld", out_valid, 0);
    chk("abort.bus", outbus, 0);
    chk("abort.done", done, 0);
    step();
    #3 rst_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) chk("abort.ghost", out_valid, 0);
    end
    chk("abort.idle", busy, 0);
    run_op("u50_5", 1'b0, 8'd5, 8'd50, 8'h0A, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
